// File: rtl/div_share_sched.sv
// Round-robin shared restoring divider: one quotient bit per clock for NREQ requesters.
// Optional build macro DIV_EARLY_ZERO_EN: divide-by-zero skips the step sequence entirely.
module div_share_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dividend,
    input  logic [NREQ*WIDTH-1:0] divisor,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [WIDTH-1:0]      quotient,
    output logic [WIDTH-1:0]      remainder,
    output logic                  div_by_zero
);

    localparam int CW = $clog2(WIDTH);

`ifdef DIV_EARLY_ZERO_EN
    localparam bit EARLY_ZERO = 1'b1;
`else
    localparam bit EARLY_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   p_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] dvs_r;
    logic [IDW-1:0]   id_r;

    logic [NREQ-1:0]  gnt_r;
    logic             busy_r;
    logic             done_r;
    logic [IDW-1:0]   done_id_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_by_zero_r;

    logic             win_vld_s;
    logic [IDW-1:0]   win_idx_s;
    logic [IDW-1:0]   idx_s;
    logic [WIDTH-1:0] win_dvd_s;
    logic [WIDTH-1:0] win_dvs_s;
    logic [NREQ-1:0]  gnt_nxt_s;
    logic [IDW-1:0]   ptr_nxt_s;
    logic [WIDTH:0]   p_sh_s;
    logic [WIDTH:0]   p_nxt_s;
    logic [WIDTH-1:0] d_nxt_s;

    assign gnt         = gnt_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign done_id     = done_id_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = div_by_zero_r;

    // Round-robin search from the pointer upward, first requester found wins
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = '0;
        idx_s     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = IDW'((int'(rr_ptr_r) + k) % NREQ);
            if (!win_vld_s && req[idx_s]) begin
                win_vld_s = 1'b1;
                win_idx_s = idx_s;
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // Winner's operands, grant vector and the pointer value that follows it
    always_comb begin
        win_dvd_s            = dividend[int'(win_idx_s)*WIDTH +: WIDTH];
        win_dvs_s            = divisor[int'(win_idx_s)*WIDTH +: WIDTH];
        gnt_nxt_s            = '0;
        gnt_nxt_s[win_idx_s] = win_vld_s;
        if (win_idx_s == IDW'(NREQ-1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = win_idx_s + 1'b1;
        end
    end

    // One restoring step; P carries an extra bit so large divisors never lose the shifted MSB
    always_comb begin
        p_sh_s = {p_r[WIDTH-1:0], d_r[WIDTH-1]};
        if (p_sh_s >= {1'b0, dvs_r}) begin
            p_nxt_s = p_sh_s - {1'b0, dvs_r};
            d_nxt_s = {d_r[WIDTH-2:0], 1'b1};
        end else begin
            p_nxt_s = p_sh_s;
            d_nxt_s = {d_r[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= '0;
            cnt_r         <= '0;
            p_r           <= '0;
            d_r           <= '0;
            dvs_r         <= '0;
            id_r          <= '0;
            gnt_r         <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            done_id_r     <= '0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            div_by_zero_r <= 1'b0;
        end else begin
            gnt_r  <= '0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (win_vld_s) begin
                        rr_ptr_r <= ptr_nxt_s;
                        gnt_r    <= gnt_nxt_s;
                        busy_r   <= 1'b1;
                        id_r     <= win_idx_s;
                        dvs_r    <= win_dvs_s;
                        p_r      <= '0;
                        d_r      <= win_dvd_s;
                        cnt_r    <= '0;
                        if (EARLY_ZERO && (win_dvs_s == '0)) begin
                            state_r       <= ST_DONE;
                            done_r        <= 1'b1;
                            done_id_r     <= win_idx_s;
                            quotient_r    <= '1;
                            remainder_r   <= win_dvd_s;
                            div_by_zero_r <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    busy_r <= 1'b1;
                    p_r    <= p_nxt_s;
                    d_r    <= d_nxt_s;
                    if (cnt_r == CW'(WIDTH-1)) begin
                        state_r       <= ST_DONE;
                        done_r        <= 1'b1;
                        done_id_r     <= id_r;
                        quotient_r    <= d_nxt_s;
                        remainder_r   <= p_nxt_s[WIDTH-1:0];
                        div_by_zero_r <= (dvs_r == '0);
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_sched.sv
// Scoreboard bench for div_share_sched (WIDTH=8, NREQ=4): expected grants and results are
// queued as stimulus is issued and checked by an independent negedge monitor.
module tb_div_share_sched;

    localparam int W = 8;
    localparam int N = 4;
`ifdef DIV_EARLY_ZERO_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 8;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] dividend = '0;
    logic [N*W-1:0] divisor = '0;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           done;
    logic [1:0]     done_id;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;

    div_share_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .dividend(dividend), .divisor(divisor),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int q;
        int r;
        int dbz;
        int lat;
    } res_t;

    res_t res_q[$];
    int   gnt_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_gnt_cyc = 0;
    int   mon_e;
    res_t mon_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input int id, input int dvd, input int dvs,
                         input int q, input int r, input int dbz, input int lat);
        res_t e;
        req[id] = 1'b1;
        dividend[id*W +: W] = W'(dvd);
        divisor[id*W +: W]  = W'(dvs);
        gnt_q.push_back(id);
        e.id = id; e.q = q; e.r = r; e.dbz = dbz; e.lat = lat;
        res_q.push_back(e);
    endtask

    // release each request on its grant; run until scoreboard drains and DUT idles
    task automatic drive(input int maxc);
        int c = 0;
        while (c < maxc && !(gnt_q.size() == 0 && res_q.size() == 0 && !busy && req == '0)) begin
            @(negedge clk);
            req = req & ~gnt;
            c++;
        end
        chk("drive_timeout", int'(c < maxc), 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt"}, int'(gnt), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_done_id"}, int'(done_id), 0);
        chk({tag, "_quotient"}, int'(quotient), 0);
        chk({tag, "_remainder"}, int'(remainder), 0);
        chk({tag, "_dbz"}, int'(div_by_zero), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // monitor: compares grants and results against the queued expectations
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != '0) begin
                if (gnt_q.size() == 0) begin
                    chk("unexpected_gnt", int'(gnt), 0);
                end else begin
                    mon_e = gnt_q.pop_front();
                    chk("gnt", int'(gnt), 1 << mon_e);
                end
                last_gnt_cyc = cyc;
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_r = res_q.pop_front();
                    chk("done_id", int'(done_id), mon_r.id);
                    chk("quotient", int'(quotient), mon_r.q);
                    chk("remainder", int'(remainder), mon_r.r);
                    chk("div_by_zero", int'(div_by_zero), mon_r.dbz);
                    chk("latency", cyc - last_gnt_cyc, mon_r.lat);
                end
            end
        end
    end

    initial begin
        int c;
        int n;
        int prev;
        repeat (2) @(negedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // single request
        issue(0, 100, 7, 14, 2, 0, 8);
        drive(40);

        // all four requesting from reset: order 0,1,2,3
        do_reset();
        issue(0, 20, 3, 6, 2, 0, 8);
        issue(1, 45, 6, 7, 3, 0, 8);
        issue(2, 99, 10, 9, 9, 0, 8);
        issue(3, 17, 17, 1, 0, 0, 8);
        drive(80);

        // pointer wrapped to 0: req0 served before req2; large-divisor cases
        issue(0, 250, 200, 1, 50, 0, 8);
        issue(2, 255, 129, 1, 126, 0, 8);
        drive(40);
        issue(3, 255, 255, 1, 0, 0, 8);
        drive(20);
        issue(3, 254, 255, 0, 254, 0, 8);
        drive(20);

        // divide by zero
        issue(1, 55, 0, 255, 55, 1, ZLAT);
        drive(20);

        // reset in the 4th RUN cycle discards the operation
        req[2] = 1'b1;
        dividend[2*W +: W] = 8'd77;
        divisor[2*W +: W]  = 8'd5;
        gnt_q.push_back(2);
        c = 0;
        while (c < 20 && !gnt[2]) begin
            @(negedge clk);
            c++;
        end
        chk("mid_gnt_timeout", int'(c < 20), 1);
        req[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);
        issue(1, 9, 3, 3, 0, 0, 8);
        drive(20);

        // sole requester holding req: grant period WIDTH+2
        issue(1, 200, 10, 20, 0, 0, 8);
        issue(1, 200, 10, 20, 0, 0, 8);
        issue(1, 200, 10, 20, 0, 0, 8);
        n = 0;
        prev = 0;
        c = 0;
        while (c < 60 && n < 3) begin
            @(negedge clk);
            c++;
            if (gnt[1]) begin
                n++;
                if (n > 1) chk("grant_period", cyc - prev, 10);
                prev = cyc;
                if (n == 3) req[1] = 1'b0;
            end
        end
        chk("hold_grants", n, 3);
        drive(30);

        chk("gnt_queue_empty", gnt_q.size(), 0);
        chk("res_queue_empty", res_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
